bp_be_dcache_trace_checker: RTL and testbench

BP_BE_DCACHE_TRACE_CHECKER -- requirements
Module: bp_be_dcache_trace_checker

---
 rtl/bp_be_dcache_pkg.sv | 19 +
 rtl/bp_be_dcache_trace_checker_fifo.sv | 59 +++++
 rtl/bp_be_dcache_trace_checker.sv | 164 ++++++++++++++++
 tb/tb_bp_be_dcache_trace_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_dcache_pkg.sv
// Shared types for the dcache trace checker: FSM states and error causes.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bp_be_dcache_pkg;

  typedef enum logic [1:0] {
    eRun   = 2'd0,
    eDone  = 2'd1,
    eError = 2'd2
  } bp_be_dcache_checker_state_e;

  typedef enum logic [1:0] {
    eErrNone     = 2'd0,
    eErrMismatch = 2'd1,
    eErrOverflow = 2'd2,
    eErrTimeout  = 2'd3
  } bp_be_dcache_checker_err_e;

endpackage

// File: rtl/bp_be_dcache_trace_checker_fifo.sv
// Small 1r1w response buffer with registered storage and full/empty flags.
// Latency: a pushed word is visible at data_o on the cycle after the push.
// Backpressure: none internally; the caller must not push when full unless popping.
//
// Ports:
//   clk_i, reset_n_i      : clock, async active-low reset (clears pointers/count)
//   v_i, data_i           : write strobe and write data
//   yumi_i                : pop the head entry
//   data_o                : head entry (valid when empty_o=0)
//   full_o, empty_o       : occupancy flags
module bp_be_dcache_trace_checker_fifo #(
  parameter int width_p = 64,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   wr_ptr_r;
  logic [ptr_w-1:0]   rd_ptr_r;
  logic [cnt_w-1:0]   cnt_r;

  // Pointers wrap naturally because els_p is a power of two.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (v_i)    wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      if (yumi_i) rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      case ({v_i, yumi_i})
        2'b10:   cnt_r <= cnt_r + cnt_w'(1);
        2'b01:   cnt_r <= cnt_r - cnt_w'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the count alone.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_r[wr_ptr_r] <= data_i;
  end

  assign data_o  = mem_r[rd_ptr_r];
  assign full_o  = (cnt_r == cnt_w'(els_p));
  assign empty_o = (cnt_r == '0);

endmodule

// File: rtl/bp_be_dcache_trace_checker.sv
// Compares dcache responses against an expected-value trace; flags done or first error.
// Latency: response compared when it reaches the buffer head and exp_v_i is high; flags one cycle later.
// Backpressure: none on v_i; a push into a full buffer with no pop is dropped and flagged as overflow.
//
// Optional: define BP_BE_DCACHE_CHECKER_WATCHDOG_EN to build in an idle-timeout watchdog.
//
// Ports:
//   clk_i, reset_n_i       : clock, async active-low reset
//   v_i, data_i            : dcache response (no ready)
//   exp_v_i, exp_data_i    : expected-value stream from the trace node
//   exp_yumi_o             : consumes the current expected word
//   done_o, error_o        : terminal status flags (registered)
//   err_cause_o            : first error cause (0 none, 1 mismatch, 2 overflow/extra, 3 timeout)
//   resp_count_o           : number of responses compared (saturating)
//   err_data_o             : buffer head captured at the first mismatch
module bp_be_dcache_trace_checker
  import bp_be_dcache_pkg::*;
#(
  parameter int data_width_p  = 64,
  parameter int instr_count_p = 16,
  parameter int fifo_els_p    = 4,
  parameter int timeout_p     = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 v_i,
  input  logic [data_width_p-1:0]              data_i,
  input  logic                                 exp_v_i,
  input  logic [data_width_p-1:0]              exp_data_i,
  output logic                                 exp_yumi_o,
  output logic                                 done_o,
  output logic                                 error_o,
  output logic [1:0]                           err_cause_o,
  output logic [$clog2(instr_count_p+1)-1:0]   resp_count_o,
  output logic [data_width_p-1:0]              err_data_o
);

  localparam int cnt_w = $clog2(instr_count_p + 1);

  bp_be_dcache_checker_state_e state_r, state_n;
  bp_be_dcache_checker_err_e   err_cause_r, err_cause_n;
  logic [cnt_w-1:0]            resp_count_r;
  logic [data_width_p-1:0]     err_data_r;

  logic                    in_run;
  logic                    push_req, fifo_push, pop;
  logic                    fifo_full, fifo_empty;
  logic [data_width_p-1:0] head;
  logic                    overflow, mismatch, last_pop, count_sat;
  logic                    timeout_hit;

  assign in_run    = (state_r == eRun);
  assign push_req  = v_i & in_run;
  assign pop       = ~fifo_empty & exp_v_i & in_run;
  // Pushing into a full buffer is only safe when the head leaves in the same cycle.
  assign overflow  = push_req & fifo_full & ~pop;
  assign fifo_push = push_req & ~overflow;
  assign mismatch  = pop & (head != exp_data_i);
  assign count_sat = (resp_count_r == cnt_w'(instr_count_p));
  assign last_pop  = pop & (resp_count_r == cnt_w'(instr_count_p - 1));

  bp_be_dcache_trace_checker_fifo #(
    .width_p (data_width_p),
    .els_p   (fifo_els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (fifo_push),
    .data_i    (data_i),
    .yumi_i    (pop),
    .data_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

`ifdef BP_BE_DCACHE_CHECKER_WATCHDOG_EN
  localparam int wd_w = $clog2(timeout_p + 1);

  logic [wd_w-1:0] wd_cnt_r;
  logic            wd_idle;

  // Any response attempt or pop counts as activity.
  assign wd_idle = in_run & ~push_req & ~pop;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_cnt_r <= '0;
    end else if (!wd_idle) begin
      wd_cnt_r <= '0;
    end else if (wd_cnt_r != wd_w'(timeout_p)) begin
      wd_cnt_r <= wd_cnt_r + wd_w'(1);
    end
  end

  // Fires on the idle cycle that brings the idle run up to timeout_p.
  assign timeout_hit = wd_idle & (wd_cnt_r >= wd_w'(timeout_p - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= eRun;
      err_cause_r <= eErrNone;
    end else begin
      state_r     <= state_n;
      err_cause_r <= err_cause_n;
    end
  end

  // Next-state logic; the cause only changes when leaving eRun/eDone, so it records the first error.
  always_comb begin
    state_n     = state_r;
    err_cause_n = err_cause_r;
    case (state_r)
      eRun: begin
        if (mismatch) begin
          state_n     = eError;
          err_cause_n = eErrMismatch;
        end else if (overflow) begin
          state_n     = eError;
          err_cause_n = eErrOverflow;
        end else if (timeout_hit) begin
          state_n     = eError;
          err_cause_n = eErrTimeout;
        end else if (last_pop) begin
          state_n     = eDone;
        end
      end
      eDone: begin
        if (v_i) begin
          state_n     = eError;
          err_cause_n = eErrOverflow;
        end
      end
      default: begin
        state_n = state_r;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    done_o  = (state_r == eDone);
    error_o = (state_r == eError);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_count_r <= '0;
      err_data_r   <= '0;
    end else begin
      if (pop && !count_sat) resp_count_r <= resp_count_r + cnt_w'(1);
      if (mismatch)          err_data_r   <= head;
    end
  end

  assign exp_yumi_o   = pop;
  assign err_cause_o  = err_cause_r;
  assign resp_count_o = resp_count_r;
  assign err_data_o   = err_data_r;

endmodule

// File: tb/tb_bp_be_dcache_trace_checker.sv
module tb_bp_be_dcache_trace_checker;

  localparam int DW   = 64;
  localparam int NCNT = 4;
  localparam int NELS = 4;
  localparam int TOUT = 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          v_i;
  logic [DW-1:0] data_i;
  logic          exp_v_i;
  logic [DW-1:0] exp_data_i;
  logic          exp_yumi_o;
  logic          done_o;
  logic          error_o;
  logic [1:0]    err_cause_o;
  logic [2:0]    resp_count_o;
  logic [DW-1:0] err_data_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk_i = ~clk_i;

  bp_be_dcache_trace_checker #(
    .data_width_p  (DW),
    .instr_count_p (NCNT),
    .fifo_els_p    (NELS),
    .timeout_p     (TOUT)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .exp_v_i      (exp_v_i),
    .exp_data_i   (exp_data_i),
    .exp_yumi_o   (exp_yumi_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .err_cause_o  (err_cause_o),
    .resp_count_o (resp_count_o),
    .err_data_o   (err_data_o)
  );

  // Reference model: 0 running, 1 done, 2 error; buffer held as a queue.
  int            m_state;
  logic [DW-1:0] m_q[$];
  int            m_cnt;
  int            m_cause;
  logic [DW-1:0] m_errdata;
  int            m_idle;

  function automatic logic model_yumi();
    return (m_state == 0) && (m_q.size() > 0) && (exp_v_i === 1'b1);
  endfunction

  task automatic model_reset();
    m_state = 0; m_q.delete(); m_cnt = 0; m_cause = 0; m_errdata = '0; m_idle = 0;
  endtask

  task automatic model_step();
    int            cause;
    logic          y;
    logic [DW-1:0] h;
    cause = 0;
    if (m_state == 0) begin
      y = model_yumi();
      if (y) begin
        h = m_q.pop_front();
        if (m_cnt < NCNT) m_cnt++;
        if (h !== exp_data_i) begin cause = 1; m_errdata = h; end
      end
      if (v_i) begin
        if (m_q.size() < NELS) m_q.push_back(data_i);
        else if (cause == 0) cause = 2;
      end
`ifdef BP_BE_DCACHE_CHECKER_WATCHDOG_EN
      if (y || v_i) m_idle = 0; else m_idle++;
      if (cause == 0 && m_idle >= TOUT) cause = 3;
`endif
      if (cause != 0) begin m_state = 2; m_cause = cause; end
      else if (m_cnt == NCNT) m_state = 1;
    end else if (m_state == 1 && v_i) begin
      m_state = 2; m_cause = 2;
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ev, input logic [DW-1:0] ed);
    v_i = v; data_i = d; exp_v_i = ev; exp_data_i = ed;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    v_i = 0; data_i = '0; exp_v_i = 0; exp_data_i = '0;
    reset_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    model_reset();
  endtask

  // Four in-order matching responses; the expected word trails the response by one cycle.
  task automatic run_match();
    logic [DW-1:0] vals [4];
    vals = '{64'h11, 64'h22, 64'h33, 64'h44};
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, vals[i % 4], 1'b1, (i > 0) ? vals[(i + 3) % 4] : '0);
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; v_i = 1; data_i = 64'hFF; exp_v_i = 1; exp_data_i = 64'hEE;
    #3;
    checks++; if (done_o !== 1'b0)        begin fails++; $display("FAIL reset_done got %b want 0", done_o); end
    checks++; if (error_o !== 1'b0)       begin fails++; $display("FAIL reset_error got %b want 0", error_o); end
    checks++; if (err_cause_o !== 2'd0)   begin fails++; $display("FAIL reset_cause got %0d want 0", err_cause_o); end
    checks++; if (resp_count_o !== 3'd0)  begin fails++; $display("FAIL reset_count got %0d want 0", resp_count_o); end
    checks++; if (err_data_o !== 64'h0)   begin fails++; $display("FAIL reset_errdata got %0h want 0", err_data_o); end
    checks++; if (exp_yumi_o !== 1'b0)    begin fails++; $display("FAIL reset_yumi got %b want 0", exp_yumi_o); end
  endtask

  task automatic test_match();
    logic [DW-1:0] vals [4];
    vals = '{64'h11, 64'h22, 64'h33, 64'h44};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, vals[i % 4], 1'b1, (i > 0) ? vals[(i + 3) % 4] : '0);
      checks++; if (exp_yumi_o !== (i > 0)) begin fails++; $display("FAIL match_yumi[%0d] got %b want %b", i, exp_yumi_o, (i > 0)); end
      tick();
      checks++; if (resp_count_o !== 3'(i)) begin fails++; $display("FAIL match_count[%0d] got %0d want %0d", i, resp_count_o, i); end
      checks++; if (done_o !== (i == 4))    begin fails++; $display("FAIL match_done[%0d] got %b want %b", i, done_o, (i == 4)); end
    end
    checks++; if (error_o !== 1'b0) begin fails++; $display("FAIL match_error got %b want 0", error_o); end
  endtask

  task automatic test_mismatch();
    apply_reset();
    drive(1, 64'hA, 1, '0);     tick();
    drive(1, 64'hC, 1, 64'hA);
    checks++; if (exp_yumi_o !== 1'b1) begin fails++; $display("FAIL mm_yumi got %b want 1", exp_yumi_o); end
    tick();
    checks++; if (error_o !== 1'b0) begin fails++; $display("FAIL mm_early_error got %b want 0", error_o); end
    drive(0, '0, 1, 64'hB);     tick();
    checks++; if (error_o !== 1'b1)       begin fails++; $display("FAIL mm_error got %b want 1", error_o); end
    checks++; if (err_cause_o !== 2'd1)   begin fails++; $display("FAIL mm_cause got %0d want 1", err_cause_o); end
    checks++; if (err_data_o !== 64'hC)   begin fails++; $display("FAIL mm_errdata got %0h want c", err_data_o); end
    checks++; if (resp_count_o !== 3'd2)  begin fails++; $display("FAIL mm_count got %0d want 2", resp_count_o); end
    // Error is terminal and the first cause sticks.
    drive(1, 64'h7, 1, 64'h8);  tick();
    checks++; if (err_cause_o !== 2'd1 || error_o !== 1'b1) begin fails++; $display("FAIL mm_sticky got cause %0d err %b want 1 1", err_cause_o, error_o); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 64'hA0 + 64'(i), 0, '0);
      tick();
      checks++; if (error_o !== (i == 4)) begin fails++; $display("FAIL ovf_error[%0d] got %b want %b", i, error_o, (i == 4)); end
      checks++; if (err_cause_o !== ((i == 4) ? 2'd2 : 2'd0)) begin fails++; $display("FAIL ovf_cause[%0d] got %0d want %0d", i, err_cause_o, (i == 4) ? 2 : 0); end
    end
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] vals [4];
    vals = '{64'h51, 64'h52, 64'h53, 64'h54};
    apply_reset();
    for (int i = 0; i < 4; i++) begin drive(1, vals[i], 0, '0); tick(); end
    drive(1, 64'h55, 1, vals[0]);
    checks++; if (exp_yumi_o !== 1'b1) begin fails++; $display("FAIL full_yumi got %b want 1", exp_yumi_o); end
    tick();
    checks++; if (error_o !== 1'b0) begin fails++; $display("FAIL full_pushpop_error got %b want 0", error_o); end
    for (int i = 1; i < 4; i++) begin
      drive(0, '0, 1, vals[i]);
      tick();
      checks++; if (error_o !== 1'b0)    begin fails++; $display("FAIL full_drain_error[%0d] got %b want 0", i, error_o); end
      checks++; if (done_o !== (i == 3)) begin fails++; $display("FAIL full_drain_done[%0d] got %b want %b", i, done_o, (i == 3)); end
    end
  endtask

  task automatic test_extra();
    apply_reset();
    run_match();
    checks++; if (done_o !== 1'b1) begin fails++; $display("FAIL extra_pre_done got %b want 1", done_o); end
    drive(1, 64'h99, 0, '0); tick();
    drive(0, '0, 0, '0);
    checks++; if (error_o !== 1'b1)     begin fails++; $display("FAIL extra_error got %b want 1", error_o); end
    checks++; if (err_cause_o !== 2'd2) begin fails++; $display("FAIL extra_cause got %0d want 2", err_cause_o); end
    checks++; if (done_o !== 1'b0)      begin fails++; $display("FAIL extra_done got %b want 0", done_o); end
  endtask

  task automatic test_watchdog();
    logic want;
    apply_reset();
    for (int k = 1; k <= TOUT; k++) begin
      drive(0, '0, 0, '0);
      tick();
`ifdef BP_BE_DCACHE_CHECKER_WATCHDOG_EN
      want = (k == TOUT);
`else
      want = 1'b0;
`endif
      checks++; if (error_o !== want) begin fails++; $display("FAIL wd_error[%0d] got %b want %b", k, error_o, want); end
      checks++; if (err_cause_o !== (want ? 2'd3 : 2'd0)) begin fails++; $display("FAIL wd_cause[%0d] got %0d want %0d", k, err_cause_o, want ? 3 : 0); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1, 64'h5, 0, '0);     tick();
    drive(1, 64'h6, 1, 64'h5);  tick();
    drive(1, 64'h7, 0, '0);     tick();
    drive(0, '0, 1, 64'h6);
    checks++; if (resp_count_o !== 3'd1 || exp_yumi_o !== 1'b1) begin fails++; $display("FAIL arst_pre got cnt %0d yumi %b want 1 1", resp_count_o, exp_yumi_o); end
    reset_n_i = 1'b0;
    #1;
    checks++; if (resp_count_o !== 3'd0) begin fails++; $display("FAIL arst_count got %0d want 0", resp_count_o); end
    checks++; if (exp_yumi_o !== 1'b0)   begin fails++; $display("FAIL arst_yumi got %b want 0", exp_yumi_o); end
    checks++; if (done_o !== 1'b0 || error_o !== 1'b0 || err_cause_o !== 2'd0 || err_data_o !== 64'h0)
      begin fails++; $display("FAIL arst_flags got d%b e%b c%0d ed%0h want all 0", done_o, error_o, err_cause_o, err_data_o); end
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    model_reset();
    run_match();
    checks++; if (done_o !== 1'b1 || resp_count_o !== 3'd4 || error_o !== 1'b0)
      begin fails++; $display("FAIL arst_rerun got d%b cnt %0d e%b want 1 4 0", done_o, resp_count_o, error_o); end
  endtask

  task automatic test_random();
    logic          v, ev;
    logic [DW-1:0] d, ed;
    for (int r = 0; r < 8; r++) begin
      apply_reset();
      for (int c = 0; c < 30; c++) begin
        v  = 1'($urandom_range(0, 1));
        d  = 64'($urandom_range(0, 255));
        ev = 1'($urandom_range(0, 1));
        ed = (m_q.size() > 0 && $urandom_range(0, 9) != 0) ? m_q[0] : 64'($urandom_range(0, 255));
        drive(v, d, ev, ed);
        checks++; if (exp_yumi_o !== model_yumi()) begin fails++; $display("FAIL rnd_yumi[%0d.%0d] got %b want %b", r, c, exp_yumi_o, model_yumi()); end
        tick();
        checks++; if (done_o !== (m_state == 1))   begin fails++; $display("FAIL rnd_done[%0d.%0d] got %b want %b", r, c, done_o, (m_state == 1)); end
        checks++; if (error_o !== (m_state == 2))  begin fails++; $display("FAIL rnd_error[%0d.%0d] got %b want %b", r, c, error_o, (m_state == 2)); end
        checks++; if (err_cause_o !== 2'(m_cause)) begin fails++; $display("FAIL rnd_cause[%0d.%0d] got %0d want %0d", r, c, err_cause_o, m_cause); end
        checks++; if (resp_count_o !== 3'(m_cnt))  begin fails++; $display("FAIL rnd_count[%0d.%0d] got %0d want %0d", r, c, resp_count_o, m_cnt); end
        checks++; if (err_data_o !== m_errdata)    begin fails++; $display("FAIL rnd_errdata[%0d.%0d] got %0h want %0h", r, c, err_data_o, m_errdata); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_match();
    test_mismatch();
    test_overflow();
    test_full_pushpop();
    test_extra();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
